// File: rtl/sd_sector_pkg.sv
// Shared types and constants for the SD sector-transfer engine.
// Sector geometry, FSM states and the byte-lane helper live here.
package sd_sector_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int SECTOR_WORDS = 256;
    localparam int SYNC_DEPTH   = 2;

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        ISSUE,
        XFER,
        DONE,
        FAIL
    } state_t;

    function automatic logic [7:0] byte_sel(
        input logic [15:0] word,
        input logic        hi
    );
        return hi ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sd_sector_engine_if.sv
// SD-side byte interface of the sector engine.
// The engine is the master; the SPI/SD block is the slave.
interface sd_sector_engine_if;

    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_dout;
    logic        sd_dout_strobe;
    logic [7:0]  sd_din;
    logic        sd_din_strobe;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        output sd_din,
        input  sd_ack,
        input  sd_dout,
        input  sd_dout_strobe,
        input  sd_din_strobe
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        input  sd_din,
        output sd_ack,
        output sd_dout,
        output sd_dout_strobe,
        output sd_din_strobe
    );

endinterface

// File: rtl/sd_sector_engine_ram.sv
// 256x16 dual-port sector buffer: host word port, engine byte-enable port.
// Both read ports are registered with one cycle of latency.
module sector_ram_w16
    import sd_sector_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  a_addr,
    input  logic        a_we,
    input  logic [15:0] a_din,
    output logic [15:0] a_dout,
    input  logic [7:0]  b_addr,
    input  logic [1:0]  b_be,
    input  logic [15:0] b_din,
    output logic [15:0] b_dout
);

    logic [15:0] mem [SECTOR_WORDS];

    // Host and engine never write in the same cycle: host writes are gated by busy.
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_din;
        end
        if (b_be[0]) begin
            mem[b_addr][7:0] <= b_din[7:0];
        end
        if (b_be[1]) begin
            mem[b_addr][15:8] <= b_din[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_dout <= '0;
            b_dout <= '0;
        end else begin
            a_dout <= mem[a_addr];
            b_dout <= mem[b_addr];
        end
    end

endmodule

// File: rtl/sd_sector_engine.sv
// Single-sector read/write engine between the word-side controller and
// the SD byte interface, with a private 512-byte buffer.
module sd_sector_engine #(
    parameter logic [23:0] TIMEOUT      = 24'd10_000_000,
    parameter int          SECTOR_BYTES = sd_sector_pkg::SECTOR_BYTES
) (
    input  logic        clk_ram,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_lba,
    output logic        busy,
    output logic        done,
    output logic        error,
    input  logic [7:0]  buf_addr,
    input  logic        buf_we,
    input  logic [15:0] buf_din,
    output logic [15:0] buf_dout,
    sd_sector_engine_if.master sd
);

    import sd_sector_pkg::*;

    localparam logic [9:0] FULL = 10'(SECTOR_BYTES);

    state_t state;
    state_t state_n;

    logic [SYNC_DEPTH-1:0] ack_sync;
    logic [SYNC_DEPTH:0]   dstb_sync;
    logic [SYNC_DEPTH:0]   cstb_sync;

    logic        ack;
    logic        dout_pulse;
    logic        din_pulse;
    logic        xfer_pulse;
    logic        tmo_hit;
    logic        is_wr;
    logic        wr_n;
    logic        pre;
    logic        b_hi;
    logic        b_we;
    logic [1:0]  b_be;
    logic [9:0]  cnt;
    logic [23:0] tmo;
    logic [15:0] b_dout;

    sector_ram_w16 u_ram (
        .clk    (clk_ram),
        .reset  (reset),
        .a_addr (buf_addr),
        .a_we   (buf_we && !busy),
        .a_din  (buf_din),
        .a_dout (buf_dout),
        .b_addr (cnt[8:1]),
        .b_be   (b_be),
        .b_din  ({sd.sd_dout, sd.sd_dout}),
        .b_dout (b_dout)
    );

    // Async SD-side inputs; the strobe chains carry one extra stage for edge detect.
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            ack_sync  <= '0;
            dstb_sync <= '0;
            cstb_sync <= '0;
        end else begin
            ack_sync  <= {ack_sync[SYNC_DEPTH-2:0], sd.sd_ack};
            dstb_sync <= {dstb_sync[SYNC_DEPTH-1:0], sd.sd_dout_strobe};
            cstb_sync <= {cstb_sync[SYNC_DEPTH-1:0], sd.sd_din_strobe};
        end
    end

    always_comb begin
        ack        = ack_sync[SYNC_DEPTH-1];
        dout_pulse = dstb_sync[SYNC_DEPTH-1] & ~dstb_sync[SYNC_DEPTH];
        din_pulse  = cstb_sync[SYNC_DEPTH-1] & ~cstb_sync[SYNC_DEPTH];
        xfer_pulse = (state == XFER)
                   && (is_wr ? din_pulse : dout_pulse)
                   && (cnt != FULL);
        b_we       = xfer_pulse && !is_wr;
        b_be       = 2'b00;
        if (b_we) begin
            b_be = cnt[0] ? 2'b10 : 2'b01;
        end
        tmo_hit    = (TIMEOUT != 24'd0) && (tmo + 24'd1 == TIMEOUT);
        wr_n       = (state == IDLE) ? req_wr : is_wr;
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req_rd && req_wr) begin
                    state_n = FAIL;
                end else if (req_wr) begin
                    state_n = PRELOAD;
                end else if (req_rd) begin
                    state_n = ISSUE;
                end
            end
            PRELOAD: begin
                if (pre) begin
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (ack) begin
                    state_n = XFER;
                end else if (tmo_hit) begin
                    state_n = FAIL;
                end
            end
            XFER: begin
                if (!ack) begin
                    state_n = (cnt == FULL) ? DONE : FAIL;
                end
            end
            DONE:    state_n = IDLE;
            FAIL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_ram) begin
        if (reset) begin
            cnt   <= '0;
            tmo   <= '0;
            is_wr <= 1'b0;
            pre   <= 1'b0;
            b_hi  <= 1'b0;
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
            end else if (xfer_pulse) begin
                cnt <= cnt + 10'd1;
            end
            tmo   <= (state == ISSUE) ? tmo + 24'd1 : '0;
            is_wr <= wr_n;
            pre   <= (state == PRELOAD) && !pre;
            b_hi  <= cnt[0];
        end
    end

    // sd_din trails cnt by two cycles: RAM read, then lane select.
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            sd.sd_rd  <= 1'b0;
            sd.sd_wr  <= 1'b0;
            sd.sd_lba <= '0;
            sd.sd_din <= '0;
        end else begin
            busy     <= state_n inside {PRELOAD, ISSUE, XFER};
            done     <= state_n == DONE;
            error    <= state_n == FAIL;
            sd.sd_rd <= (state_n == ISSUE) && !wr_n;
            sd.sd_wr <= (state_n == ISSUE) && wr_n;
            if (state == IDLE && state_n inside {PRELOAD, ISSUE}) begin
                sd.sd_lba <= req_lba;
            end
            if (is_wr && state inside {PRELOAD, ISSUE, XFER}) begin
                sd.sd_din <= byte_sel(b_dout, b_hi);
            end
        end
    end

endmodule

// File: tb/tb_sd_sector_engine.sv
// Randomised bench for sd_sector_engine with a byte-level SD-side model.
// Expected buffer/stream contents come from a plain byte array.
module tb_sd_sector_engine;

    logic        clk_ram = 1'b0;
    logic        reset   = 1'b1;
    logic        req_rd  = 1'b0;
    logic        req_wr  = 1'b0;
    logic [31:0] req_lba = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  buf_addr = '0;
    logic        buf_we   = 1'b0;
    logic [15:0] buf_din  = '0;
    logic [15:0] buf_dout;

    int checks   = 0;
    int failures = 0;
    int n_done   = 0;
    int n_err    = 0;

    logic [7:0] exp_b [512];
    logic [7:0] got_b [512];

    sd_sector_engine_if sd ();

    sd_sector_engine #(
        .TIMEOUT (24'd50)
    ) dut (
        .clk_ram  (clk_ram),
        .reset    (reset),
        .req_rd   (req_rd),
        .req_wr   (req_wr),
        .req_lba  (req_lba),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .buf_addr (buf_addr),
        .buf_we   (buf_we),
        .buf_din  (buf_din),
        .buf_dout (buf_dout),
        .sd       (sd)
    );

    always #5 clk_ram = ~clk_ram;

    always @(posedge clk_ram) begin
        if (done === 1'b1) n_done++;
        if (error === 1'b1) n_err++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: run did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_ram);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic request(input logic r, input logic w, input logic [31:0] lba);
        req_rd  = r;
        req_wr  = w;
        req_lba = lba;
        tick();
        req_rd  = 1'b0;
        req_wr  = 1'b0;
    endtask

    task automatic host_write(input logic [7:0] a, input logic [15:0] d);
        buf_addr = a;
        buf_din  = d;
        buf_we   = 1'b1;
        tick();
        buf_we   = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, output logic [15:0] d);
        buf_addr = a;
        tick();
        d = buf_dout;
    endtask

    task automatic wait_req(input bit wr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if ((wr ? sd.sd_wr : sd.sd_rd) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic send_bytes(input int n, input int hi, input int lo, input bit poke);
        for (int i = 0; i < n; i++) begin
            sd.sd_dout = (i < 512) ? exp_b[i] : 8'(i * 7 + 3);
            sd.sd_dout_strobe = 1'b1;
            tick(hi);
            sd.sd_dout_strobe = 1'b0;
            tick(lo);
            if (poke && i == 50) begin
                request(1'b0, 1'b1, 32'hFFFF_0000);
                tick(2);
                chk("busy_wr_ignored", 32'(sd.sd_wr), 32'd0);
            end
            if (poke && i == 120) begin
                host_write(8'd10, 16'hDEAD);
            end
        end
    endtask

    task automatic run_read(input logic [31:0] lba, input int nbytes,
                            input int hi, input int lo, input bit poke);
        bit ok;
        bit full;
        int d0;
        int e0;
        full = nbytes >= 512;
        d0 = n_done;
        e0 = n_err;
        request(1'b1, 1'b0, lba);
        wait_req(1'b0, ok);
        chk("rd_req_seen", 32'(ok), 32'd1);
        chk("rd_lba", sd.sd_lba, lba);
        sd.sd_ack = 1'b1;
        tick(4);
        chk("rd_drop_on_ack", 32'(sd.sd_rd), 32'd0);
        chk("rd_busy", 32'(busy), 32'd1);
        send_bytes(nbytes, hi, lo, poke);
        sd.sd_ack = 1'b0;
        tick(2);
        chk("rd_no_early_pulse", 32'({done, error}), 32'd0);
        tick(1);
        chk("rd_done", 32'(done), 32'(full));
        chk("rd_error", 32'(error), 32'(!full));
        tick(2);
        chk("rd_idle", 32'({busy, sd.sd_rd, sd.sd_wr}), 32'd0);
        chk("rd_lba_kept", sd.sd_lba, lba);
        chk("rd_done_cnt", 32'(n_done - d0), 32'(full ? 1 : 0));
        chk("rd_err_cnt", 32'(n_err - e0), 32'(full ? 0 : 1));
    endtask

    task automatic check_buf(input string tag);
        logic [15:0] w;
        for (int k = 0; k < 256; k++) begin
            host_read(8'(k), w);
            chk($sformatf("%s[%0d]", tag, k), 32'(w),
                32'({exp_b[2*k+1], exp_b[2*k]}));
        end
    endtask

    task automatic run_write(input logic [31:0] lba, input int hi, input int lo);
        bit ok;
        int d0;
        int e0;
        for (int k = 0; k < 256; k++) begin
            host_write(8'(k), {exp_b[2*k+1], exp_b[2*k]});
        end
        d0 = n_done;
        e0 = n_err;
        request(1'b0, 1'b1, lba);
        wait_req(1'b1, ok);
        chk("wr_req_seen", 32'(ok), 32'd1);
        chk("wr_din_byte0", 32'(sd.sd_din), 32'(exp_b[0]));
        chk("wr_lba", sd.sd_lba, lba);
        sd.sd_ack = 1'b1;
        tick(4);
        chk("wr_drop_on_ack", 32'(sd.sd_wr), 32'd0);
        for (int i = 0; i < 512; i++) begin
            got_b[i] = sd.sd_din;
            sd.sd_din_strobe = 1'b1;
            tick(hi);
            sd.sd_din_strobe = 1'b0;
            tick(lo);
        end
        sd.sd_ack = 1'b0;
        tick(3);
        chk("wr_done", 32'(done), 32'd1);
        tick(2);
        chk("wr_done_cnt", 32'(n_done - d0), 32'd1);
        chk("wr_err_cnt", 32'(n_err - e0), 32'd0);
        for (int i = 0; i < 512; i++) begin
            chk($sformatf("wr_byte[%0d]", i), 32'(got_b[i]), 32'(exp_b[i]));
        end
    endtask

    initial begin
        logic [15:0] w;
        int n;
        int d0;
        int e0;
        int hi;
        int lo;
        logic [31:0] lba;

        sd.sd_ack         = 1'b0;
        sd.sd_dout        = '0;
        sd.sd_dout_strobe = 1'b0;
        sd.sd_din_strobe  = 1'b0;

        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulses", 32'({done, error}), 32'd0);
        chk("rst_rdwr", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
        chk("rst_lba", sd.sd_lba, 32'd0);
        chk("rst_din", 32'(sd.sd_din), 32'd0);
        chk("rst_dout", 32'(buf_dout), 32'd0);
        reset = 1'b0;
        tick(2);

        // Full read with a ramp pattern.
        for (int i = 0; i < 512; i++) exp_b[i] = 8'(i);
        run_read(32'h1234, 512, 3, 3, 1'b0);
        host_read(8'd0, w);
        chk("rd_word0", 32'(w), 32'h0100);
        host_read(8'd127, w);
        chk("rd_word127", 32'(w), 32'hFFFE);
        check_buf("rd_buf");

        // Full write of word n = A500+n.
        for (int k = 0; k < 256; k++) begin
            exp_b[2*k]   = 8'(k);
            exp_b[2*k+1] = 8'hA5;
        end
        run_write(32'h0000_BEEF, 3, 3);
        chk("wr_b1", 32'(got_b[1]), 32'hA5);
        chk("wr_b510", 32'(got_b[510]), 32'hFF);
        chk("wr_b511", 32'(got_b[511]), 32'hA5);

        // Short read.
        for (int i = 0; i < 512; i++) exp_b[i] = 8'($urandom);
        run_read(32'h0000_0100, 100, 3, 3, 1'b0);

        // Timeout with no ack.
        e0 = n_err;
        request(1'b1, 1'b0, 32'h4444);
        chk("tmo_rd_high", 32'(sd.sd_rd), 32'd1);
        n = 0;
        while (n < 80 && error !== 1'b1) begin
            tick();
            n++;
        end
        chk("tmo_window", 32'(n >= 50 && n <= 52), 32'd1);
        chk("tmo_rd_low", 32'(sd.sd_rd), 32'd0);
        tick(2);
        chk("tmo_err_cnt", 32'(n_err - e0), 32'd1);

        // Simultaneous read and write request.
        d0 = n_done;
        e0 = n_err;
        request(1'b1, 1'b1, 32'h5555);
        chk("ill_error", 32'(error), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        chk("ill_rdwr", 32'({sd.sd_rd, sd.sd_wr}), 32'd0);
        tick(3);
        chk("ill_rdwr_after", 32'({sd.sd_rd, sd.sd_wr, busy}), 32'd0);
        chk("ill_pulses", 32'((n_err - e0) * 16 + (n_done - d0)), 32'h10);

        // Read with an overlapping write request and a host write while busy.
        for (int i = 0; i < 512; i++) exp_b[i] = 8'($urandom);
        run_read(32'h0000_0A0A, 512, 3, 3, 1'b1);
        check_buf("ovl_buf");

        // Reset in the middle of a read.
        for (int i = 0; i < 512; i++) exp_b[i] = 8'($urandom);
        request(1'b1, 1'b0, 32'h66);
        sd.sd_ack = 1'b1;
        tick(4);
        send_bytes(200, 3, 3, 1'b0);
        d0 = n_done;
        e0 = n_err;
        reset = 1'b1;
        sd.sd_ack = 1'b0;
        tick();
        reset = 1'b0;
        chk("mid_rst_rd", 32'(sd.sd_rd), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick(8);
        chk("mid_rst_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        for (int i = 0; i < 512; i++) exp_b[i] = 8'($urandom);
        run_read(32'h77, 512, 3, 3, 1'b0);
        check_buf("post_rst_buf");

        // Randomised mix; some reads overrun the sector.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 512; i++) exp_b[i] = 8'($urandom);
            hi  = int'($urandom_range(3, 4));
            lo  = int'($urandom_range(3, 5));
            lba = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                run_read(lba, 512 + int'($urandom_range(0, 6)), hi, lo, 1'b0);
                check_buf("rnd_rd_buf");
            end else begin
                run_write(lba, hi, lo);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_sector_engine.md
Name: sd_sector_engine

Overview:
- Sector-transfer engine between the disk controller (word side) and the SPI-side SD byte interface (sd_rd/sd_wr/sd_ack/byte strobes).
- Owns one 512-byte sector buffer, packed as 256 × 16-bit words.
- Accepts a single-sector read or write request for an LBA and runs the sd_* handshake. Captures incoming bytes into the buffer, or supplies outgoing bytes from it, then reports done or error.
- The controller fills or drains the buffer through a word port while the engine is idle.

Parameters:
- TIMEOUT, default 24'd10_000_000: clk_ram cycles allowed from request until sd_ack is first seen high. 0 disables the timeout.
- SECTOR_BYTES, default 512: bytes per transfer. Fixed; the value is documented, not meant to be varied.

Ports:
- clk_ram  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req_rd  in  1  one-cycle pulse: read sector req_lba into the buffer.
- req_wr  in  1  one-cycle pulse: write the buffer to sector req_lba.
- req_lba  in  32  sector number; sampled on the request cycle.
- busy  out  1  high from the accepted request until done/error.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  one-cycle pulse on timeout, short transfer or illegal request.
- buf_addr  in  8  word address.
- buf_we  in  1  word write; ignored while busy.
- buf_din  in  16  write data; low byte is the even byte.
- buf_dout  out  16  read data; registered, 1-cycle latency.
- sd_lba  out  32  latched LBA.
- sd_rd  out  1  read request to the SD side.
- sd_wr  out  1  write request to the SD side.
- sd_ack  in  1  async; SD side is servicing the request.
- sd_dout  in  8  read byte; valid around sd_dout_strobe.
- sd_dout_strobe  in  1  async; one pulse per received byte.
- sd_din  out  8  next byte to send.
- sd_din_strobe  in  1  async; one pulse per byte consumed.

Behaviour:
- Synchronisation:
  - sd_ack, sd_dout_strobe and sd_din_strobe each pass through a 2-FF synchroniser.
  - Strobes are converted to single-cycle pulses on the synchronised rising edge.
  - sd_dout is sampled together with that pulse.
- Reset values: busy=0, done=0, error=0, sd_rd=0, sd_wr=0, sd_lba=0, sd_din=0, buf_dout=0, state IDLE, byte counter 0. Buffer contents are preserved.
- Reset mid-transfer: sd_rd/sd_wr drop the next cycle and the engine returns to IDLE. No done or error pulse is issued.
- Requests:
  - Accepted only in IDLE.
  - A request arriving while busy is ignored, with no pulse.
  - req_rd and req_wr in the same cycle: error pulse, no transfer, busy stays 0.
- States:
  - IDLE → PRELOAD (write) or ISSUE (read) on request. busy=1 and sd_lba=req_lba, both registered.
  - PRELOAD: read buffer byte 0 and load sd_din (2 cycles), then → ISSUE.
  - ISSUE: assert sd_rd or sd_wr and start the timeout counter.
    - Synced ack=1 → XFER, dropping sd_rd/sd_wr in the same cycle.
    - Counter reaches TIMEOUT → FAIL.
  - XFER, read: each dout pulse writes the byte at byte index cnt (even → [7:0], odd → [15:8] of word cnt[8:1]), then cnt++.
  - XFER, write: each din pulse increments cnt. sd_din is updated to byte cnt+1 within 3 cycles; the SD side is guaranteed slower than this.
  - XFER, saturation: bytes beyond 512 are ignored and cnt saturates at 512.
  - XFER exit: synced ack falls → DONE if cnt==512, else FAIL.
  - DONE: done pulse, busy=0 → IDLE.
  - FAIL: error pulse, busy=0, sd_rd/sd_wr=0 → IDLE.
- Host buffer port:
  - buf_dout reflects buf_addr from the previous cycle, including while busy (contents are in flux during a read).
  - buf_we while busy is dropped.
- Completion latency: done rises 3 cycles after the raw sd_ack falls (2 sync + 1).

Decomposition:
- Package sd_sector_pkg holds:
  - state enum (IDLE, PRELOAD, ISSUE, XFER, DONE, FAIL);
  - SECTOR_BYTES = 512 and SECTOR_WORDS = 256;
  - synchroniser depth = 2.
- One sub-module: sector_ram_w16, a 256×16 true dual-port RAM.
  - Host port: word access.
  - Engine port: word address plus 2-bit byte enable for byte writes; byte reads use a word read plus a mux on cnt[0].

Test Plan:
1. Read: req_rd, lba=32'h1234. Model asserts ack and sends bytes 0..255,0..255, then drops ack. Expect sd_rd to drop on the ack edge, sd_lba=32'h1234 and one done pulse; buf word 0=16'h0100 and word 127=16'hFFFE.
2. Write: preload word n = 16'hA500+n. On req_wr, sd_din=8'h00 before sd_wr rises. The model captures 512 bytes: byte 1=8'hA5 and byte 511=8'hA5; byte 510=8'hFF. Expect done.
3. Short read: ack drops after 100 bytes → error pulse, no done, busy=0, sd_rd=0.
4. Timeout: TIMEOUT=50, ack never rises → error pulse 50–52 cycles after the request, sd_rd=0.
5. Illegal and overlapping requests:
   - req_rd and req_wr together → error pulse, sd_rd=sd_wr=0.
   - req_wr during a busy read → ignored; the read still completes with done.
   - buf_we during a busy read → word unchanged.
6. Reset at byte 200 of a read → sd_rd=0 and busy=0 next cycle, no pulses. A following read completes normally.
